// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter and fixed-latency sequencer for the shared memory port.
// Each grant runs IDLE -> ACCESS (WAIT_CYCLES) -> RESP, with a one-cycle ack in RESP.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic [1:0]        i_Req,
    input  logic [1:0]        i_WE,
    input  logic [ADDR_W-1:0] i_Addr0,
    input  logic [ADDR_W-1:0] i_Addr1,
    input  logic [DATA_W-1:0] i_WData0,
    input  logic [DATA_W-1:0] i_WData1,
    output logic [1:0]        o_Ack,
    output logic [DATA_W-1:0] o_RData,
    output logic              o_CoreStall,
    output logic              o_Busy,
    output logic              o_MemEn,
    output logic              o_MemWE,
    output logic [ADDR_W-1:0] o_MemAddr,
    output logic [DATA_W-1:0] o_MemWData,
    input  logic [DATA_W-1:0] i_MemRData
);

    localparam int unsigned CNT_W = 4;

    if (WAIT_CYCLES == 0 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("mem_port_arbiter: WAIT_CYCLES must be in 1..15");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t              state_q,     state_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic                last_q,      last_d;
    logic                owner_q,     owner_d;
    logic                mem_en_q,    mem_en_d;
    logic                mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   rdata_q,     rdata_d;
    logic [1:0]          ack_q,       ack_d;
    logic                busy_q,      busy_d;
    logic                grant;

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        owner_d     = owner_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        ack_d       = 2'b00;
        grant       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_Req != 2'b00) begin
                    // On a tie the port that did not win last time gets the grant
                    grant       = (i_Req == 2'b11) ? ~last_q : i_Req[1];
                    owner_d     = grant;
                    last_d      = grant;
                    mem_en_d    = 1'b1;
                    mem_we_d    = i_WE[grant];
                    mem_addr_d  = grant ? i_Addr1 : i_Addr0;
                    mem_wdata_d = grant ? i_WData1 : i_WData0;
                    cnt_d       = CNT_W'(WAIT_CYCLES);
                    state_d     = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    rdata_d        = i_MemRData;
                    ack_d[owner_q] = 1'b1;
                    state_d        = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            ack_q       <= 2'b00;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
        end
    end

    assign o_Ack       = ack_q;
    assign o_RData     = rdata_q;
    assign o_Busy      = busy_q;
    assign o_MemEn     = mem_en_q;
    assign o_MemWE     = mem_we_q;
    assign o_MemAddr   = mem_addr_q;
    assign o_MemWData  = mem_wdata_q;
    assign o_CoreStall = i_Req[0] & ~ack_q[0];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances (WAIT_CYCLES 1, 3, 4) share stimulus,
// each backed by its own small memory model that commits writes on the strobe edge.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [31:0] addr0, addr1, wdata0, wdata1;

    logic [1:0]  ack    [3];
    logic [31:0] rdata  [3];
    logic        stall  [3];
    logic        busy   [3];
    logic        men    [3];
    logic        mwe    [3];
    logic [31:0] maddr  [3];
    logic [31:0] mwdata [3];
    logic [31:0] mrdata [3];
    logic [31:0] mem    [3][256];

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) u_w1 (
        .i_Clk(clk), .i_Reset(rst_n), .i_Req(req), .i_WE(we),
        .i_Addr0(addr0), .i_Addr1(addr1), .i_WData0(wdata0), .i_WData1(wdata1),
        .o_Ack(ack[0]), .o_RData(rdata[0]), .o_CoreStall(stall[0]), .o_Busy(busy[0]),
        .o_MemEn(men[0]), .o_MemWE(mwe[0]), .o_MemAddr(maddr[0]), .o_MemWData(mwdata[0]),
        .i_MemRData(mrdata[0]));

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(3)) u_w3 (
        .i_Clk(clk), .i_Reset(rst_n), .i_Req(req), .i_WE(we),
        .i_Addr0(addr0), .i_Addr1(addr1), .i_WData0(wdata0), .i_WData1(wdata1),
        .o_Ack(ack[1]), .o_RData(rdata[1]), .o_CoreStall(stall[1]), .o_Busy(busy[1]),
        .o_MemEn(men[1]), .o_MemWE(mwe[1]), .o_MemAddr(maddr[1]), .o_MemWData(mwdata[1]),
        .i_MemRData(mrdata[1]));

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(4)) u_w4 (
        .i_Clk(clk), .i_Reset(rst_n), .i_Req(req), .i_WE(we),
        .i_Addr0(addr0), .i_Addr1(addr1), .i_WData0(wdata0), .i_WData1(wdata1),
        .o_Ack(ack[2]), .o_RData(rdata[2]), .o_CoreStall(stall[2]), .o_Busy(busy[2]),
        .o_MemEn(men[2]), .o_MemWE(mwe[2]), .o_MemAddr(maddr[2]), .o_MemWData(mwdata[2]),
        .i_MemRData(mrdata[2]));

    // Read data is stable for the whole access because the address is held through ACCESS
    always_comb begin
        for (int k = 0; k < 3; k++) mrdata[k] = mem[k][maddr[k][7:0]];
    end

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++)
            if (men[k] && mwe[k]) mem[k][maddr[k][7:0]] = mwdata[k];
    end

    task automatic do_reset();
        req   = 2'b00;
        we    = 2'b00;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        req = 2'b00; we = 2'b00;
        rst_n = 1'b0;
        @(negedge clk);
        total++; if (ack[1] !== 2'b00) begin bad++; $display("FAIL rst_ack got=%h want=0", ack[1]); end
        total++; if (rdata[1] !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h want=0", rdata[1]); end
        total++; if (men[1] !== 1'b0 || mwe[1] !== 1'b0) begin bad++; $display("FAIL rst_mem_en_we got=%b%b want=00", men[1], mwe[1]); end
        total++; if (maddr[1] !== 32'h0 || mwdata[1] !== 32'h0) begin bad++; $display("FAIL rst_mem_bus addr=%h wdata=%h want=0", maddr[1], mwdata[1]); end
        total++; if (busy[1] !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy[1]); end
        req = 2'b01;
        #1;
        total++; if (stall[1] !== 1'b1) begin bad++; $display("FAIL rst_stall got=%b want=1", stall[1]); end
        req = 2'b00;
        #1;
        total++; if (stall[1] !== 1'b0) begin bad++; $display("FAIL rst_stall_low got=%b want=0", stall[1]); end
    endtask

    task automatic test_single_read();
        do_reset();
        req = 2'b01; we = 2'b00; addr0 = 32'h10;
        #1;
        total++; if (stall[0] !== 1'b1) begin bad++; $display("FAIL rd_stall_req got=%b want=1", stall[0]); end
        @(negedge clk);
        total++; if (men[0] !== 1'b1 || maddr[0] !== 32'h10 || mwe[0] !== 1'b0) begin
            bad++; $display("FAIL rd_strobe en=%b addr=%h we=%b want en=1 addr=10 we=0", men[0], maddr[0], mwe[0]); end
        total++; if (ack[0] !== 2'b00 || stall[0] !== 1'b1 || busy[0] !== 1'b1) begin
            bad++; $display("FAIL rd_access ack=%h stall=%b busy=%b want 0 1 1", ack[0], stall[0], busy[0]); end
        @(negedge clk);
        total++; if (ack[0] !== 2'b01 || rdata[0] !== 32'hDEADBEEF) begin
            bad++; $display("FAIL rd_ack ack=%h rdata=%h want 01 deadbeef", ack[0], rdata[0]); end
        total++; if (stall[0] !== 1'b0 || men[0] !== 1'b0) begin
            bad++; $display("FAIL rd_resp stall=%b en=%b want 0 0", stall[0], men[0]); end
        req = 2'b00;
        @(negedge clk);
        total++; if (ack[0] !== 2'b00 || busy[0] !== 1'b0) begin
            bad++; $display("FAIL rd_idle ack=%h busy=%b want 0 0", ack[0], busy[0]); end
    endtask

    task automatic test_write_then_read();
        int n;
        do_reset();
        req = 2'b10; we = 2'b10; addr1 = 32'h40; wdata1 = 32'h1234_5678;
        n = 0;
        do begin @(negedge clk); n++; end while (ack[1] === 2'b00 && n < 20);
        total++; if (n != 4 || ack[1] !== 2'b10) begin bad++; $display("FAIL wr_ack cycles=%0d ack=%h want 4 10", n, ack[1]); end
        total++; if (mem[1][8'h40] !== 32'h1234_5678) begin bad++; $display("FAIL wr_commit got=%h want=12345678", mem[1][8'h40]); end
        req = 2'b00; we = 2'b00;
        @(negedge clk);
        req = 2'b01; addr0 = 32'h40;
        n = 0;
        do begin @(negedge clk); n++; end while (ack[1] === 2'b00 && n < 20);
        total++; if (n != 4 || ack[1] !== 2'b01) begin bad++; $display("FAIL rb_ack cycles=%0d ack=%h want 4 01", n, ack[1]); end
        total++; if (rdata[1] !== 32'h1234_5678) begin bad++; $display("FAIL rb_data got=%h want=12345678", rdata[1]); end
        req = 2'b00;
    endtask

    task automatic test_contention();
        int          n_ack;
        int          both;
        logic [1:0]  got_o [3];
        int          got_t [3];
        logic [31:0] got_d [3];
        logic [1:0]  exp_o [3] = '{2'b01, 2'b10, 2'b01};
        int          exp_t [3] = '{4, 9, 14};
        logic [31:0] exp_d [3] = '{32'hA000_0010, 32'hA000_0020, 32'hA000_0010};
        do_reset();
        req = 2'b11; we = 2'b00; addr0 = 32'h10; addr1 = 32'h20;
        n_ack = 0; both = 0;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            if (ack[1] === 2'b11) both++;
            if (ack[1] !== 2'b00) begin
                if (n_ack < 3) begin got_o[n_ack] = ack[1]; got_t[n_ack] = n; got_d[n_ack] = rdata[1]; end
                n_ack++;
            end
            if (n == 14) req = 2'b00;
        end
        total++; if (n_ack != 3) begin bad++; $display("FAIL ct_count got=%0d want=3", n_ack); end
        total++; if (both != 0) begin bad++; $display("FAIL ct_both_acks got=%0d want=0", both); end
        for (int k = 0; k < 3; k++) begin
            total++; if (got_o[k] !== exp_o[k] || got_t[k] != exp_t[k] || got_d[k] !== exp_d[k]) begin
                bad++; $display("FAIL ct_grant%0d ack=%h t=%0d data=%h want %h %0d %h",
                                k, got_o[k], got_t[k], got_d[k], exp_o[k], exp_t[k], exp_d[k]); end
        end
    endtask

    task automatic test_withdrawn();
        int         n_ack;
        logic [1:0] got_o [2];
        int         got_t [2];
        do_reset();
        req = 2'b11; we = 2'b00; addr0 = 32'h10; addr1 = 32'h20;
        @(negedge clk);
        total++; if (men[1] !== 1'b1 || maddr[1] !== 32'h10) begin
            bad++; $display("FAIL wd_strobe en=%b addr=%h want 1 10", men[1], maddr[1]); end
        req = 2'b10;
        n_ack = 0;
        for (int n = 2; n <= 16; n++) begin
            @(negedge clk);
            if (ack[1] !== 2'b00) begin
                if (n_ack < 2) begin got_o[n_ack] = ack[1]; got_t[n_ack] = n; end
                n_ack++;
                if (ack[1][1] === 1'b1) req = 2'b00;
            end
        end
        total++; if (n_ack != 2) begin bad++; $display("FAIL wd_count got=%0d want=2", n_ack); end
        total++; if (got_o[0] !== 2'b01 || got_t[0] != 4) begin
            bad++; $display("FAIL wd_core_ack ack=%h t=%0d want 01 4", got_o[0], got_t[0]); end
        total++; if (got_o[1] !== 2'b10 || got_t[1] != 9) begin
            bad++; $display("FAIL wd_loader_ack ack=%h t=%0d want 10 9", got_o[1], got_t[1]); end
    endtask

    task automatic test_reset_mid();
        int n;
        int stray;
        do_reset();
        req = 2'b01; we = 2'b00; addr0 = 32'h10;
        @(negedge clk);
        total++; if (men[2] !== 1'b1 || busy[2] !== 1'b1) begin
            bad++; $display("FAIL rm_first_access en=%b busy=%b want 1 1", men[2], busy[2]); end
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        total++; if (busy[2] !== 1'b0 || maddr[2] !== 32'h0 || ack[2] !== 2'b00 || men[2] !== 1'b0 || rdata[2] !== 32'h0) begin
            bad++; $display("FAIL rm_async busy=%b addr=%h ack=%h en=%b rdata=%h want all 0",
                            busy[2], maddr[2], ack[2], men[2], rdata[2]); end
        req = 2'b11; addr1 = 32'h20;
        stray = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack[2] !== 2'b00) stray++;
        end
        total++; if (stray != 0) begin bad++; $display("FAIL rm_no_ack got=%0d want=0", stray); end
        rst_n = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (ack[2] === 2'b00 && n < 20);
        total++; if (n != 5 || ack[2] !== 2'b01) begin
            bad++; $display("FAIL rm_first_tie cycles=%0d ack=%h want 5 01", n, ack[2]); end
        req = 2'b00;
    endtask

    task automatic test_back_to_back();
        int n_ack;
        int idle_cnt;
        int got_t [3];
        do_reset();
        req = 2'b01; we = 2'b00; addr0 = 32'h10;
        n_ack = 0; idle_cnt = 0;
        for (int n = 1; n <= 18; n++) begin
            @(negedge clk);
            if (ack[1] !== 2'b00) begin
                if (n_ack < 3) got_t[n_ack] = n;
                n_ack++;
            end
            if (n >= 5 && n <= 13 && busy[1] === 1'b0) idle_cnt++;
            if (n == 14) req = 2'b00;
        end
        total++; if (n_ack != 3) begin bad++; $display("FAIL b2b_count got=%0d want=3", n_ack); end
        total++; if (got_t[0] != 4 || got_t[1] != 9 || got_t[2] != 14) begin
            bad++; $display("FAIL b2b_spacing t=%0d,%0d,%0d want 4,9,14", got_t[0], got_t[1], got_t[2]); end
        total++; if (idle_cnt != 2) begin bad++; $display("FAIL b2b_bubble got=%0d want=2", idle_cnt); end
    endtask

    initial begin
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 256; i++) mem[k][i] = 32'hA000_0000 + 32'(i);
        mem[0][8'h10] = 32'hDEADBEEF;
        rst_n = 1'b0; req = 2'b00; we = 2'b00;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

        test_reset();
        test_single_read();
        test_write_then_read();
        test_contention();
        test_withdrawn();
        test_reset_mid();
        test_back_to_back();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
